id_ex_operand_stage: RTL and testbench

// - ID->EX pipeline stage on the producer side of the ALU operand path.
// - Decodes the RV32I immediate from the instruction word and derives the control bits alusrc and mem_write.
// - Registers imm, both register operands, alusrc, mem_write and pc behind a valid/ready handshake.
// - Its outputs drive the EX-stage ALU source mux directly: out_imm->immediate, out_reg_data2->reg_data2, out_alusrc->ctrl, out_mem_write->mem_write.

---
 rtl/id_ex_operand_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID->EX operand stage: RV32I immediate decode, alusrc/mem_write
// derivation and a one-entry valid/ready register slice.
module id_ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg_data1,
    input  logic [XLEN-1:0] reg_data2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_reg_data1,
    output logic [XLEN-1:0] out_reg_data2,
    output logic [XLEN-1:0] out_pc,
    output logic            out_alusrc,
    output logic            out_mem_write,
    output logic            out_illegal
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic            is_i;
    logic            is_s;
    logic            is_b;
    logic            is_u;
    logic            is_j;
    logic            is_r;
    logic            sgn;
    logic [XLEN-1:0] imm_d;
    logic            alusrc_d;
    logic            mem_write_d;
    logic            illegal_d;
    logic            load;

    assign opcode = instr[6:0];
    assign sgn    = instr[31];

    assign is_i = (opcode == OP_IMM) || (opcode == LOAD) || (opcode == JALR);
    assign is_s = (opcode == STORE);
    assign is_b = (opcode == BRANCH);
    assign is_u = (opcode == LUI) || (opcode == AUIPC);
    assign is_j = (opcode == JAL);
    assign is_r = (opcode == OP);

    always_comb begin
        imm_d       = '0;
        alusrc_d    = 1'b0;
        mem_write_d = 1'b0;
        illegal_d   = 1'b0;
        unique case (1'b1)
            is_i: begin
                imm_d    = {{20{sgn}}, instr[31:20]};
                alusrc_d = 1'b1;
            end
            is_s: begin
                imm_d       = {{20{sgn}}, instr[31:25], instr[11:7]};
                alusrc_d    = 1'b1;
                mem_write_d = 1'b1;
            end
            is_b: begin
                imm_d = {{19{sgn}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            is_u: begin
                imm_d    = {instr[31:12], 12'b0};
                alusrc_d = 1'b1;
            end
            is_j: begin
                imm_d = {{11{sgn}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            end
            is_r: begin
                imm_d = '0;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on load, so it holds through stalls and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm       <= '0;
            out_reg_data1 <= '0;
            out_reg_data2 <= '0;
            out_pc        <= '0;
            out_alusrc    <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (load) begin
            out_imm       <= imm_d;
            out_reg_data1 <= reg_data1;
            out_reg_data2 <= reg_data2;
            out_pc        <= pc;
            out_alusrc    <= alusrc_d;
            out_mem_write <= mem_write_d;
            out_illegal   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed spec vectors plus random
// traffic against a field-extraction reference model.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_reg_data1;
    logic [31:0] out_reg_data2;
    logic [31:0] out_pc;
    logic        out_alusrc;
    logic        out_mem_write;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic        alusrc;
        logic        memw;
        logic        ill;
    } beat_t;

    beat_t exp_b;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr(instr),
        .pc(pc),
        .reg_data1(reg_data1),
        .reg_data2(reg_data2),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm(out_imm),
        .out_reg_data1(out_reg_data1),
        .out_reg_data2(out_reg_data2),
        .out_pc(out_pc),
        .out_alusrc(out_alusrc),
        .out_mem_write(out_mem_write),
        .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic beat_t decode(input logic [31:0] w,
                                     input logic [31:0] r1,
                                     input logic [31:0] r2,
                                     input logic [31:0] p);
        beat_t b;
        logic [12:0] bimm;
        logic [20:0] jimm;
        logic [11:0] simm;
        b.valid  = 1'b1;
        b.rd1    = r1;
        b.rd2    = r2;
        b.pc     = p;
        b.imm    = 0;
        b.alusrc = 0;
        b.memw   = 0;
        b.ill    = 0;
        simm = {w[31:25], w[11:7]};
        bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                b.imm = 32'($signed(w) >>> 20);
                b.alusrc = 1;
            end
            7'h23: begin
                b.imm = 32'($signed(simm));
                b.alusrc = 1;
                b.memw = 1;
            end
            7'h63: b.imm = 32'($signed(bimm));
            7'h37, 7'h17: begin
                b.imm = w & 32'hFFFFF000;
                b.alusrc = 1;
            end
            7'h6F: b.imm = 32'($signed(jimm));
            7'h33: b.imm = 0;
            default: b.ill = 1;
        endcase
        return b;
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(exp_b.valid));
        if (exp_b.valid) begin
            check({tag, ".imm"}, out_imm, exp_b.imm);
            check({tag, ".rd1"}, out_reg_data1, exp_b.rd1);
            check({tag, ".rd2"}, out_reg_data2, exp_b.rd2);
            check({tag, ".pc"}, out_pc, exp_b.pc);
            check({tag, ".alusrc"}, 32'(out_alusrc), 32'(exp_b.alusrc));
            check({tag, ".memw"}, 32'(out_mem_write), 32'(exp_b.memw));
            check({tag, ".ill"}, 32'(out_illegal), 32'(exp_b.ill));
        end
    endtask

    // Drive one cycle of inputs, check in_ready, clock, update model, check.
    task automatic cycle(input string tag, input logic v, input logic [31:0] w,
                         input logic [31:0] p, input logic [31:0] r1,
                         input logic [31:0] r2, input logic f, input logic ordy);
        logic rdy;
        in_valid  = v;
        instr     = w;
        pc        = p;
        reg_data1 = r1;
        reg_data2 = r2;
        flush     = f;
        out_ready = ordy;
        #1;
        rdy = !exp_b.valid || ordy;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (f) exp_b.valid = 0;
        else if (v && rdy) exp_b = decode(w, r1, r2, p);
        else if (ordy) exp_b.valid = 0;
        #1;
        check_outs(tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 0);
        check({tag, ".imm"}, out_imm, 0);
        check({tag, ".rd1"}, out_reg_data1, 0);
        check({tag, ".rd2"}, out_reg_data2, 0);
        check({tag, ".pc"}, out_pc, 0);
        check({tag, ".flags"},
              32'({out_alusrc, out_mem_write, out_illegal}), 0);
        check({tag, ".in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [6:0] legal [9];
        logic [31:0] w;
        legal[0] = 7'h13; legal[1] = 7'h03; legal[2] = 7'h67;
        legal[3] = 7'h23; legal[4] = 7'h63; legal[5] = 7'h37;
        legal[6] = 7'h17; legal[7] = 7'h6F; legal[8] = 7'h33;
        exp_b = '{default: 0};
        rst_n = 0; in_valid = 0; instr = 0; pc = 0;
        reg_data1 = 0; reg_data2 = 0; flush = 0; out_ready = 0;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        cycle("addi", 1, 32'hFFB00093, 32'h100, 32'h11, 32'h22, 0, 1);
        check("addi.imm_k", out_imm, 32'hFFFFFFFB);
        check("addi.alusrc_k", 32'(out_alusrc), 1);
        cycle("sw", 1, 32'h0020A423, 32'h104, 32'h1, 32'hDEADBEEF, 0, 1);
        check("sw.imm_k", out_imm, 8);
        check("sw.memw_k", 32'(out_mem_write), 1);
        check("sw.rd2_k", out_reg_data2, 32'hDEADBEEF);
        cycle("beq", 1, 32'hFE000EE3, 32'h108, 0, 0, 0, 1);
        check("beq.imm_k", out_imm, 32'hFFFFFFFC);
        check("beq.alusrc_k", 32'(out_alusrc), 0);
        cycle("lui", 1, 32'h123452B7, 32'h10C, 0, 0, 0, 1);
        check("lui.imm_k", out_imm, 32'h12345000);
        check("lui.alusrc_k", 32'(out_alusrc), 1);

        for (int i = 0; i < 3; i++)
            cycle("stall", 1, 32'h00500113 + (i << 20), 32'h200 + i, i, i, 0, 0);
        check("stall.imm_k", out_imm, 32'h12345000);
        check("stall.in_ready_k", 32'(in_ready), 0);
        cycle("unstall", 1, 32'h00700193, 32'h300, 3, 4, 0, 1);
        check("unstall.imm_k", out_imm, 7);

        cycle("flush", 1, 32'h00900213, 32'h400, 5, 6, 1, 0);
        check("flush.valid_k", 32'(out_valid), 0);
        cycle("idle", 0, 0, 0, 0, 0, 0, 1);

        cycle("ill", 1, 32'h0000007F, 32'h500, 7, 8, 0, 0);
        check("ill.flag_k", 32'(out_illegal), 1);
        check("ill.imm_k", out_imm, 0);
        check("ill.flags_k", 32'({out_alusrc, out_mem_write}), 0);

        #2;
        rst_n = 0;
        #1;
        exp_b = '{default: 0};
        check_reset("midrst");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(9, 0) < 8) w[6:0] = legal[$urandom_range(8, 0)];
            cycle("rand", 1'($urandom_range(3, 0) != 0), w, $urandom,
                  $urandom, $urandom, 1'($urandom_range(15, 0) == 0),
                  1'($urandom_range(2, 0) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
